// File: rtl/sha3_pipe_scheduler_if.sv
// Handshake bundle between requester cores, the shared SHA3 pipe and the scheduler.
interface sha3_pipe_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  slot_id;
  logic             slot_valid;
  logic             pipe_gimme;
  logic             pipe_sample;
  logic             pipe_good;
  logic [N_REQ-1:0] res_valid;
  logic [ID_W-1:0]  res_id;
  logic             busy;
  logic             err_overflow;
  logic             err_underflow;

  modport master (
    input  req, pipe_gimme, pipe_good,
    output grant, slot_id, slot_valid, pipe_sample, res_valid, res_id,
           busy, err_overflow, err_underflow
  );

  modport slave (
    output req, pipe_gimme, pipe_good,
    input  grant, slot_id, slot_valid, pipe_sample, res_valid, res_id,
           busy, err_overflow, err_underflow
  );
endinterface

// File: rtl/sha3_pipe_scheduler.sv
// Round-robin burst sequencer sharing one iterating SHA3 pipe between N_REQ requesters;
// every burst slot is tagged so finalized results can be routed back to their owner.
module sha3_pipe_scheduler #(
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 14,
  parameter int ID_W      = 2,
  parameter int TAG_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  sha3_pipe_scheduler_if.master bus
);
  localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W  = $clog2(TAG_DEPTH + 1);
  localparam int SLOT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, BURST, WAIT} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [SLOT_W-1:0] slot_cnt;
  logic              gimme_q;
  logic              fall_seen;
  logic              err_ovf;
  logic              err_unf;

  logic [ID_W:0]     fifo_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               any_req;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    rr_next;
  int unsigned        w_idx;

  logic          start;
  logic          sampling;
  logic          granting;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic [ID_W:0] head;

  // Rotating the request vector by rr_ptr turns round-robin into a fixed-priority scan.
  always_comb begin
    req_dbl = {bus.req, bus.req} >> rr_ptr;
    req_rot = req_dbl[N_REQ-1:0];
    any_req = 1'b0;
    winner  = '0;
    w_idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!any_req && req_rot[i]) begin
        any_req = 1'b1;
        w_idx   = int'(rr_ptr) + i;
        if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
        winner  = ID_W'(w_idx);
      end
    end
    rr_next = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
  end

  // Outputs are gated by rst so an asserted reset silences the pipe and requesters at once.
  always_comb begin
    start    = (state == IDLE) && bus.pipe_gimme && any_req && !rst;
    sampling = start || ((state == BURST) && !rst);
    granting = sampling && any_req;
    full     = (count == CNT_W'(TAG_DEPTH));
    pop      = bus.pipe_good && (count != '0);
    push_ok  = sampling && (!full || pop);
    head     = fifo_mem[rd_ptr];

    bus.pipe_sample   = sampling;
    bus.slot_valid    = granting;
    bus.grant         = granting ? (N_REQ'(1) << winner) : '0;
    bus.slot_id       = granting ? winner : '0;
    bus.res_valid     = (pop && head[ID_W]) ? (N_REQ'(1) << head[ID_W-1:0]) : '0;
    bus.res_id        = (pop && head[ID_W]) ? head[ID_W-1:0] : '0;
    bus.busy          = (state != IDLE) || (count != '0);
    bus.err_overflow  = err_ovf;
    bus.err_underflow = err_unf;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {granting, bus.slot_id};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      slot_cnt  <= '0;
      gimme_q   <= 1'b0;
      fall_seen <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
    end else begin
      gimme_q <= bus.pipe_gimme;
      if (granting) rr_ptr <= rr_next;

      // The pipe's gimme fall may land late in the burst, so it is tracked from BURST onward.
      case (state)
        IDLE: begin
          if (start) begin
            state     <= BURST;
            slot_cnt  <= SLOT_W'(1);
            fall_seen <= 1'b0;
          end
        end
        BURST: begin
          if (gimme_q && !bus.pipe_gimme) fall_seen <= 1'b1;
          if (slot_cnt == SLOT_W'(BURST_LEN - 1)) begin
            state    <= WAIT;
            slot_cnt <= '0;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (gimme_q && !bus.pipe_gimme) fall_seen <= 1'b1;
          if (fall_seen && bus.pipe_gimme && !gimme_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (push_ok) wr_ptr <= (wr_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;

      if (sampling && full && !pop)           err_ovf <= 1'b1;
      if (bus.pipe_good && (count == '0))     err_unf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sha3_pipe_scheduler.sv
// Directed bench for sha3_pipe_scheduler: a tag scoreboard fed at each sample slot and
// drained on each pipe_good pulse.
module tb_sha3_pipe_scheduler;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [2:0]  exp_q [$];
  int unsigned tb_ptr;

  sha3_pipe_scheduler_if #(.N_REQ(4), .ID_W(2)) bus ();

  sha3_pipe_scheduler #(
    .N_REQ(4), .BURST_LEN(14), .ID_W(2), .TAG_DEPTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned pick(input logic [3:0] r, input int unsigned p);
    int unsigned idx;
    for (int i = 0; i < 4; i++) begin
      idx = (p + i) % 4;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.pipe_gimme = 1'b0;
    bus.pipe_good = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tb_ptr = 0;
    exp_q.delete();
  endtask

  // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic step(input logic [3:0] r, input logic g, input logic gd, input logic exp_sample);
    logic [2:0]  e;
    int unsigned win;
    bus.req = r;
    bus.pipe_gimme = g;
    bus.pipe_good = gd;
    @(negedge clk);
    chk("pipe_sample", bus.pipe_sample, exp_sample);
    if (gd) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("res_valid", bus.res_valid, e[2] ? (4'b0001 << e[1:0]) : 4'b0000);
        chk("res_id", bus.res_id, e[2] ? e[1:0] : 2'd0);
      end else begin
        chk("res_valid_empty", bus.res_valid, 4'b0000);
      end
    end else begin
      chk("res_valid_idle", bus.res_valid, 4'b0000);
    end
    if (exp_sample) begin
      if (r != 4'b0000) begin
        win = pick(r, tb_ptr);
        chk("grant", bus.grant, 4'b0001 << win);
        chk("slot_id", bus.slot_id, win);
        chk("slot_valid", bus.slot_valid, 1'b1);
        exp_q.push_back({1'b1, 2'(win)});
        tb_ptr = (win + 1) % 4;
      end else begin
        chk("grant_bubble", bus.grant, 4'b0000);
        chk("slot_valid_bubble", bus.slot_valid, 1'b0);
        exp_q.push_back(3'b000);
      end
    end else begin
      chk("grant_off", bus.grant, 4'b0000);
      chk("slot_valid_off", bus.slot_valid, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input logic [3:0] r_first, input logic [3:0] r_later,
                           input int n_first, input logic good_during);
    for (int s = 0; s < 14; s++)
      step((s < n_first) ? r_first : r_later, 1'b1, good_during, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int s = 0; s < n; s++) step(4'b0000, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tb_ptr = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.pipe_gimme = 1'b0;
    bus.pipe_good = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 4'b0000);
    chk("rst_slot_id", bus.slot_id, 2'd0);
    chk("rst_sample", bus.pipe_sample, 1'b0);
    chk("rst_res_valid", bus.res_valid, 4'b0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", {bus.err_overflow, bus.err_underflow}, 2'b00);
    rst = 1'b0;

    // Single requester
    do_reset();
    run_burst(4'b0100, 4'b0100, 14, 1'b0);
    chk("t1_busy_pending", bus.busy, 1'b1);
    drain(14);
    chk("t1_busy_done", bus.busy, 1'b0);

    // Round robin
    do_reset();
    run_burst(4'b1111, 4'b1111, 14, 1'b0);
    drain(14);
    chk("t2_busy_done", bus.busy, 1'b0);

    // Bubbles after five valid slots
    do_reset();
    run_burst(4'b0010, 4'b0000, 5, 1'b0);
    drain(14);
    chk("t3_busy_done", bus.busy, 1'b0);
    chk("t3_err", {bus.err_overflow, bus.err_underflow}, 2'b00);

    // Overlapping bursts: second burst pushes while the first drains
    do_reset();
    run_burst(4'b1111, 4'b1111, 14, 1'b0);
    run_burst(4'b1010, 4'b0101, 7, 1'b1);
    drain(14);
    chk("t4_busy_done", bus.busy, 1'b0);
    chk("t4_err", {bus.err_overflow, bus.err_underflow}, 2'b00);

    // Underflow is sticky
    do_reset();
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("t5_underflow", bus.err_underflow, 1'b1);
    for (int s = 0; s < 3; s++) step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t5_underflow_sticky", bus.err_underflow, 1'b1);
    chk("t5_overflow", bus.err_overflow, 1'b0);

    // Async reset mid-burst at slot 7
    do_reset();
    for (int s = 0; s < 7; s++) step(4'b1111, 1'b1, 1'b0, 1'b1);
    bus.req = 4'b1111;
    bus.pipe_gimme = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", bus.grant, 4'b0000);
    chk("mid_rst_sample", bus.pipe_sample, 1'b0);
    chk("mid_rst_slot_valid", bus.slot_valid, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_err", {bus.err_overflow, bus.err_underflow}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tb_ptr = 0;
    exp_q.delete();
    step(4'b0000, 1'b1, 1'b1, 1'b0);
    chk("mid_rst_underflow", bus.err_underflow, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("mid_rst_underflow_sticky", bus.err_underflow, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
